fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_src_match.sv | 38 +++
 rtl/fwd_hazard_unit.sv | 114 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Purpose: shared types and constants for the forwarding / load-use hazard unit.
//   slot_t   : one shadow-pipeline entry (valid, writes rd, destination tag, is load)
//   SEL_*    : encodings of the EX operand forward selects
package fwd_pkg;

  // Register tags are zero-extended into a fixed-width field so that one
  // struct serves every REG_AW up to this width.
  localparam int unsigned RD_MAX_W = 8;

  localparam int unsigned SEL_RF    = 0;
  localparam int unsigned SEL_EXMEM = 1;
  localparam int unsigned SEL_MEMWB = 2;

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic [RD_MAX_W-1:0] rd;
    logic                ld;
  } slot_t;

endpackage

// File: rtl/fwd_src_match.sv
// Purpose: priority search of the forwarding slots for one source register.
// Ports:
//   i_slots     : forwardable slots, index 0 = EX (nearest)
//   i_src       : source register tag (zero-extended)
//   o_match     : some slot produces i_src
//   o_sel       : latch index of the nearest producer (slot k -> k+1), 0 if none
//   o_not_ready : nearest producer is a load whose data is not yet in a latch
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned SEL_W      = $clog2(DEPTH)
) (
  input  slot_t [DEPTH-2:0]    i_slots,
  input  logic  [RD_MAX_W-1:0] i_src,
  output logic                 o_match,
  output logic  [SEL_W-1:0]    o_sel,
  output logic                 o_not_ready
);

  // Walk from oldest to nearest so the nearest hit overwrites older ones;
  // a not-ready nearest hit therefore never falls through to an older one.
  always_comb begin
    o_match     = 1'b0;
    o_sel       = SEL_W'(SEL_RF);
    o_not_ready = 1'b0;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      if (i_slots[k].valid && i_slots[k].wr &&
          (i_slots[k].rd != '0) && (i_slots[k].rd == i_src)) begin
        o_match     = 1'b1;
        o_sel       = SEL_W'(k + 1);
        o_not_ready = i_slots[k].ld && ((k + 1) < int'(LOAD_READY));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Purpose: forwarding and load-use hazard unit beside the ID/EX register.
//   Tracks destination tags of the stages past ID, registers the EX operand
//   forward selects one cycle ahead, and raises a combinational load-use stall.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   hold_i                 : freeze the whole pipeline
//   flush_i                : squash the ID instruction
//   id_*                   : ID-stage instruction fields
//   stall_o                : load-use stall (combinational)
//   fwd_a_o, fwd_b_o       : EX operand sources (0 = RF, k = latch k)
//   ex_valid_o             : EX holds a real instruction
//   stall_cnt_o            : saturating stall-cycle count
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned SEL_W      = $clog2(DEPTH),
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  output logic              stall_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic              ex_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The oldest tracked stage (WB) is covered by the write-before-read register
  // file and never forwards, so only the DEPTH-1 forwardable tags are stored.
  slot_t [DEPTH-2:0] r_slots;
  logic  [SEL_W-1:0] r_fwd_a;
  logic  [SEL_W-1:0] r_fwd_b;
  logic              r_ex_valid;
  logic  [CNT_W-1:0] r_stall_cnt;

  logic              w_match_a, w_match_b;
  logic              w_nr_a, w_nr_b;
  logic  [SEL_W-1:0] w_sel_a, w_sel_b;
  logic              w_stall;
  logic              w_bubble;
  slot_t             w_id_slot;

  fwd_src_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) u_match_a (
    .i_slots     (r_slots),
    .i_src       (RD_MAX_W'(id_rs_i)),
    .o_match     (w_match_a),
    .o_sel       (w_sel_a),
    .o_not_ready (w_nr_a)
  );

  fwd_src_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) u_match_b (
    .i_slots     (r_slots),
    .i_src       (RD_MAX_W'(id_rt_i)),
    .o_match     (w_match_b),
    .o_sel       (w_sel_b),
    .o_not_ready (w_nr_b)
  );

  // Stall decision and the entry that ID would push into EX.
  always_comb begin
    w_stall   = id_valid_i && !flush_i &&
                ((w_match_a && w_nr_a) || (w_match_b && w_nr_b));
    w_bubble  = w_stall || flush_i;
    w_id_slot = '{valid: id_valid_i, wr: id_regwrite_i,
                  rd: RD_MAX_W'(id_rd_i), ld: id_memread_i};
  end

  // Shadow pipeline, registered selects and stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_slots     <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_ex_valid  <= 1'b0;
      r_stall_cnt <= '0;
    end else if (!hold_i) begin
      for (int k = 1; k < int'(DEPTH) - 1; k++) begin
        r_slots[k] <= r_slots[k-1];
      end
      if (w_bubble) begin
        r_slots[0] <= '0;
        r_fwd_a    <= '0;
        r_fwd_b    <= '0;
        r_ex_valid <= 1'b0;
      end else begin
        r_slots[0] <= w_id_slot;
        r_fwd_a    <= id_valid_i ? w_sel_a : '0;
        r_fwd_b    <= id_valid_i ? w_sel_b : '0;
        r_ex_valid <= id_valid_i;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_o     = w_stall;
  assign fwd_a_o     = r_fwd_a;
  assign fwd_b_o     = r_fwd_b;
  assign ex_valid_o  = r_ex_valid;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose: directed self-checking bench for fwd_hazard_unit (DEPTH=3, LOAD_READY=2).
module tb_fwd_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs_i = '0;
  logic [4:0]  id_rt_i = '0;
  logic [4:0]  id_rd_i = '0;
  logic        id_regwrite_i = 1'b0;
  logic        id_memread_i = 1'b0;
  logic        stall_o;
  logic [1:0]  fwd_a_o;
  logic [1:0]  fwd_b_o;
  logic        ex_valid_o;
  logic [31:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  fwd_hazard_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .hold_i        (hold_i),
    .flush_i       (flush_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .stall_o       (stall_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .ex_valid_o    (ex_valid_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change #1 after the rising edge; everything is sampled just after that.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic ld);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = ld;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_i = 1'b0;
    n_vec++; if (fwd_a_o !== 2'd0) begin n_err++; $display("FAIL reset_fwd_a: got %0d want 0", fwd_a_o); end
    n_vec++; if (fwd_b_o !== 2'd0) begin n_err++; $display("FAIL reset_fwd_b: got %0d want 0", fwd_b_o); end
    n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid: got %0d want 0", ex_valid_o); end
    n_vec++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall_o); end
  endtask

  // add r3 ; sub rs=r3
  task automatic test_exmem_fwd();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 3, 4, 6, 1, 0);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL exmem_stall: got %0d want 0", stall_o); end
    tick();
    n_vec++; if (fwd_a_o !== 2'd1) begin n_err++; $display("FAIL exmem_fwd_a: got %0d want 1", fwd_a_o); end
    n_vec++; if (fwd_b_o !== 2'd0) begin n_err++; $display("FAIL exmem_fwd_b: got %0d want 0", fwd_b_o); end
    n_vec++; if (ex_valid_o !== 1'b1) begin n_err++; $display("FAIL exmem_ex_valid: got %0d want 1", ex_valid_o); end
  endtask

  // add r3 ; nop ; or rt=r3
  task automatic test_memwb_fwd();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 3, 7, 1, 0);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL memwb_stall: got %0d want 0", stall_o); end
    tick();
    n_vec++; if (fwd_b_o !== 2'd2) begin n_err++; $display("FAIL memwb_fwd_b: got %0d want 2", fwd_b_o); end
    n_vec++; if (fwd_a_o !== 2'd0) begin n_err++; $display("FAIL memwb_fwd_a: got %0d want 0", fwd_a_o); end
  endtask

  // add r3 ; add r3 ; and rs=rt=r3 -> nearest producer wins
  task automatic test_back_to_back();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 3, 3, 9, 1, 0); tick();
    n_vec++; if (fwd_a_o !== 2'd1) begin n_err++; $display("FAIL b2b_fwd_a: got %0d want 1", fwd_a_o); end
    n_vec++; if (fwd_b_o !== 2'd1) begin n_err++; $display("FAIL b2b_fwd_b: got %0d want 1", fwd_b_o); end
  endtask

  // lw r5 ; add rs=r5 -> one stall cycle, then MEM/WB forward
  task automatic test_load_use();
    drive(1, 1, 0, 5, 1, 1); tick();
    drive(1, 5, 2, 8, 1, 0);
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0d want 1", stall_o); end
    tick();
    n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL lu_bubble_valid: got %0d want 0", ex_valid_o); end
    n_vec++; if (fwd_a_o !== 2'd0) begin n_err++; $display("FAIL lu_bubble_fwd_a: got %0d want 0", fwd_a_o); end
    n_vec++; if (stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear: got %0d want 0", stall_o); end
    tick();
    n_vec++; if (fwd_a_o !== 2'd2) begin n_err++; $display("FAIL lu_fwd_a: got %0d want 2", fwd_a_o); end
    n_vec++; if (ex_valid_o !== 1'b1) begin n_err++; $display("FAIL lu_ex_valid: got %0d want 1", ex_valid_o); end
    n_vec++; if (stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt_o); end
  endtask

  // r0 writers and non-writers never forward
  task automatic test_no_match();
    drive(1, 1, 2, 0, 1, 0); tick();
    drive(1, 0, 0, 10, 1, 0);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %0d want 0", stall_o); end
    tick();
    n_vec++; if (fwd_a_o !== 2'd0) begin n_err++; $display("FAIL r0_fwd_a: got %0d want 0", fwd_a_o); end
    n_vec++; if (fwd_b_o !== 2'd0) begin n_err++; $display("FAIL r0_fwd_b: got %0d want 0", fwd_b_o); end
    drive(1, 1, 2, 0, 1, 1); tick();
    drive(1, 0, 0, 11, 1, 0);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL r0_load_stall: got %0d want 0", stall_o); end
    tick();
    drive(1, 1, 2, 7, 0, 0); tick();
    drive(1, 7, 7, 12, 1, 0); tick();
    n_vec++; if (fwd_a_o !== 2'd0) begin n_err++; $display("FAIL nowr_fwd_a: got %0d want 0", fwd_a_o); end
    n_vec++; if (fwd_b_o !== 2'd0) begin n_err++; $display("FAIL nowr_fwd_b: got %0d want 0", fwd_b_o); end
  endtask

  // hold during a stall freezes everything; release counts one stall
  task automatic test_hold();
    drive(1, 1, 2, 5, 1, 1); tick();
    drive(1, 5, 2, 13, 1, 0);
    hold_i = 1'b1;
    tick();
    n_vec++; if (ex_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_ex_valid: got %0d want 1", ex_valid_o); end
    n_vec++; if (stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL hold_cnt: got %0d want 1", stall_cnt_o); end
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL hold_stall: got %0d want 1", stall_o); end
    tick();
    n_vec++; if (stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL hold_cnt2: got %0d want 1", stall_cnt_o); end
    hold_i = 1'b0;
    tick();
    n_vec++; if (stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL hold_rel_cnt: got %0d want 2", stall_cnt_o); end
    n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_rel_valid: got %0d want 0", ex_valid_o); end
    tick();
    n_vec++; if (fwd_a_o !== 2'd2) begin n_err++; $display("FAIL hold_fwd_a: got %0d want 2", fwd_a_o); end
  endtask

  // flush overrides a would-be stall
  task automatic test_flush();
    drive(1, 1, 2, 5, 1, 1); tick();
    flush_i = 1'b1;
    drive(1, 5, 2, 14, 1, 0);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %0d want 0", stall_o); end
    tick();
    flush_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL flush_cnt: got %0d want 2", stall_cnt_o); end
    n_vec++; if (ex_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0d want 0", ex_valid_o); end
  endtask

  // reset with a load in EX discards it
  task automatic test_reset_midrun();
    drive(1, 1, 2, 5, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
    rst_i = 1'b1; tick();
    rst_i = 1'b0;
    n_vec++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt_o); end
    drive(1, 5, 5, 15, 1, 0);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_o); end
    tick();
    n_vec++; if (fwd_a_o !== 2'd0) begin n_err++; $display("FAIL rst_fwd_a: got %0d want 0", fwd_a_o); end
    n_vec++; if (fwd_b_o !== 2'd0) begin n_err++; $display("FAIL rst_fwd_b: got %0d want 0", fwd_b_o); end
    n_vec++; if (ex_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_ex_valid: got %0d want 1", ex_valid_o); end
  endtask

  initial begin
    test_reset();
    test_exmem_fwd();
    test_memwb_fwd();
    test_back_to_back();
    test_load_use();
    test_no_match();
    test_hold();
    test_flush();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
